// File: rtl/alu_decode_stage.sv
// ALU decode stage: turns 16-bit instruction words (including the two-word LDI)
// into a registered ALU control bundle with a valid/ready handshake on both sides.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic        use_imm,
  output logic        reg_write,
  output logic        illegal,
  output logic [15:0] instr_count,
  output logic [7:0]  illegal_count
);

  typedef enum logic {IDLE, EXT} state_t;

  state_t      state, state_nxt;
  logic        accept, load;
  logic [3:0]  op;
  logic [3:0]  ext_rd, ext_rs;
  logic [3:0]  d_alu, d_rd, d_rs, d_rt;
  logic [15:0] d_imm;
  logic        d_use_imm, d_reg_write, d_illegal;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op       = instr[15:12];

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    d_alu       = '0;
    d_rd        = '0;
    d_rs        = '0;
    d_rt        = '0;
    d_imm       = '0;
    d_use_imm   = 1'b0;
    d_reg_write = 1'b0;
    d_illegal   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          d_rd = instr[11:8];
          d_rs = instr[7:4];
          d_rt = instr[3:0];
          if (op == 4'hF) begin
            state_nxt = EXT;
          end else begin
            load = 1'b1;
            case (op)
              4'hA: begin
                d_alu       = 4'h0;
                d_use_imm   = 1'b1;
                d_imm       = {{12{instr[3]}}, instr[3:0]};
                d_rt        = '0;
                d_reg_write = 1'b1;
              end
              4'hB: begin
                d_alu       = 4'h3;
                d_use_imm   = 1'b1;
                d_imm       = {12'h000, instr[3:0]};
                d_rt        = '0;
                d_reg_write = 1'b1;
              end
              4'hC, 4'hD, 4'hE: begin
                d_illegal   = 1'b1;
              end
              default: begin
                d_alu       = op;
                d_reg_write = 1'b1;
              end
            endcase
          end
        end
        EXT: begin
          // Any word accepted here is LDI immediate data, whatever its top bits.
          state_nxt   = IDLE;
          load        = 1'b1;
          d_alu       = 4'h6;
          d_rd        = ext_rd;
          d_rs        = ext_rs;
          d_imm       = instr;
          d_use_imm   = 1'b1;
          d_reg_write = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ext_rd <= '0;
      ext_rs <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == IDLE && op == 4'hF) begin
        ext_rd <= instr[11:8];
        ext_rs <= instr[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_control   <= '0;
      rd            <= '0;
      rs            <= '0;
      rt            <= '0;
      imm           <= '0;
      use_imm       <= 1'b0;
      reg_write     <= 1'b0;
      illegal       <= 1'b0;
      instr_count   <= '0;
      illegal_count <= '0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        alu_control <= d_alu;
        rd          <= d_rd;
        rs          <= d_rs;
        rt          <= d_rt;
        imm         <= d_imm;
        use_imm     <= d_use_imm;
        reg_write   <= d_reg_write;
        illegal     <= d_illegal;
        instr_count <= instr_count + 16'd1;
        if (d_illegal && illegal_count != 8'hFF)
          illegal_count <= illegal_count + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [3:0]  alu;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_control, rd, rs, rt;
  logic [15:0] imm;
  logic        use_imm, reg_write, illegal;
  logic [15:0] instr_count;
  logic [7:0]  illegal_count;
  bundle_t     dut_b;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_valid;
  bundle_t     m_b;
  logic        m_ext;
  logic [15:0] m_first;
  int          m_cnt;
  int          m_ill;

  always #5 clk = ~clk;

  assign dut_b = {alu_control, rd, rs, rt, imm, use_imm, reg_write, illegal};

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .use_imm(use_imm), .reg_write(reg_write), .illegal(illegal),
    .instr_count(instr_count), .illegal_count(illegal_count)
  );

  function automatic bundle_t ref_bundle(input logic [15:0] w, input logic [15:0] ext);
    bundle_t b;
    int op, lo;
    op = int'(w[15:12]);
    lo = int'(w[3:0]);
    b = '0;
    b.rd = w[11:8];
    b.rs = w[7:4];
    b.rt = w[3:0];
    if (op <= 9) begin
      b.alu = w[15:12];
      b.reg_write = 1'b1;
    end else if (op == 10) begin
      if (lo > 7) lo = lo - 16;
      b.imm = 16'(lo);
      b.use_imm = 1'b1;
      b.reg_write = 1'b1;
      b.rt = '0;
    end else if (op == 11) begin
      b.alu = 4'd3;
      b.imm = 16'(lo);
      b.use_imm = 1'b1;
      b.reg_write = 1'b1;
      b.rt = '0;
    end else if (op == 15) begin
      b.alu = 4'd6;
      b.imm = ext;
      b.use_imm = 1'b1;
      b.reg_write = 1'b1;
      b.rt = '0;
    end else begin
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_b = '0; m_ext = 1'b0; m_first = '0; m_cnt = 0; m_ill = 0;
  endtask

  // Drives one cycle of stimulus, advances the model, and returns #1 after the edge.
  task automatic cycle(input logic v, input logic [15:0] w, input logic ordy);
    logic acc, load;
    bundle_t nb;
    in_valid = v; instr = w; out_ready = ordy;
    acc = v && (!m_valid || ordy);
    load = 1'b0;
    nb = '0;
    if (acc) begin
      if (m_ext) begin
        nb = ref_bundle(m_first, w); load = 1'b1; m_ext = 1'b0;
      end else if (w[15:12] == 4'hF) begin
        m_ext = 1'b1; m_first = w;
      end else begin
        nb = ref_bundle(w, 16'h0); load = 1'b1;
      end
    end
    if (load) begin
      m_valid = 1'b1; m_b = nb; m_cnt = (m_cnt + 1) % 65536;
      if (nb.illegal && m_ill < 255) m_ill++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || dut_b !== '0) begin
      errors++; $display("FAIL reset_outputs: out_valid=%b bundle=%h want 0/0", out_valid, dut_b);
    end
    checks++;
    if (instr_count !== 16'd0 || illegal_count !== 8'd0) begin
      errors++; $display("FAIL reset_counts: instr=%0d illegal=%0d want 0/0", instr_count, illegal_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    do_reset();
    cycle(1'b1, 16'h1234, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h1 || rd !== 4'd2 || rs !== 4'd3 || rt !== 4'd4
        || reg_write !== 1'b1 || use_imm !== 1'b0 || imm !== 16'h0 || illegal !== 1'b0) begin
      errors++; $display("FAIL add_bundle: v=%b bundle=%h want alu=1 rd=2 rs=3 rt=4 rw=1", out_valid, dut_b);
    end
    checks++;
    if (instr_count !== 16'd1) begin
      errors++; $display("FAIL add_count: got %0d want 1", instr_count);
    end
    cycle(1'b0, 16'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_imm();
    cycle(1'b1, 16'hA21F, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h0 || use_imm !== 1'b1 || imm !== 16'hFFFF
        || rd !== 4'd2 || rs !== 4'd1 || rt !== 4'd0 || reg_write !== 1'b1) begin
      errors++; $display("FAIL addi: bundle=%h want alu=0 imm=FFFF rd=2 rs=1 rt=0 use_imm=1", dut_b);
    end
    cycle(1'b1, 16'hB347, 1'b1);
    checks++;
    if (alu_control !== 4'h3 || use_imm !== 1'b1 || imm !== 16'h0007 || rt !== 4'd0) begin
      errors++; $display("FAIL slli: bundle=%h want alu=3 imm=0007 rt=0", dut_b);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_ldi();
    logic [15:0] c0;
    c0 = instr_count;
    cycle(1'b1, 16'hF500, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || instr_count !== c0) begin
      errors++; $display("FAIL ldi_first_word: out_valid=%b count=%0d want 0/%0d", out_valid, instr_count, c0);
    end
    cycle(1'b1, 16'hBEEF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || rd !== 4'd5 || imm !== 16'hBEEF || alu_control !== 4'h6
        || use_imm !== 1'b1 || reg_write !== 1'b1 || illegal !== 1'b0) begin
      errors++; $display("FAIL ldi_bundle: bundle=%h want rd=5 imm=BEEF alu=6 use_imm=1", dut_b);
    end
    checks++;
    if (instr_count !== c0 + 16'd1) begin
      errors++; $display("FAIL ldi_count: got %0d want %0d", instr_count, c0 + 16'd1);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    cycle(1'b1, 16'h1234, 1'b1);
    c0 = instr_count;
    in_valid = 1'b1; instr = 16'h2345; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
    end
    cycle(1'b1, 16'h2345, 1'b0);
    cycle(1'b1, 16'h2345, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h1 || rd !== 4'd2 || rs !== 4'd3 || rt !== 4'd4
        || instr_count !== c0) begin
      errors++; $display("FAIL stall_frozen: bundle=%h count=%0d want 1234-bundle count=%0d", dut_b, instr_count, c0);
    end
    cycle(1'b1, 16'h3456, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h3 || rd !== 4'd4 || rs !== 4'd5 || rt !== 4'd6
        || instr_count !== c0 + 16'd1) begin
      errors++; $display("FAIL drain_and_load: v=%b bundle=%h count=%0d", out_valid, dut_b, instr_count);
    end
    cycle(1'b1, 16'h5678, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h5 || rd !== 4'd6 || instr_count !== c0 + 16'd2) begin
      errors++; $display("FAIL back_to_back: v=%b bundle=%h count=%0d", out_valid, dut_b, instr_count);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_illegal_sat();
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      cycle(1'b1, 16'hC000, 1'b1);
      checks++;
      if (illegal !== 1'b1 || reg_write !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL illegal_flag[%0d]: illegal=%b rw=%b v=%b", i, illegal, reg_write, out_valid);
      end
      if (i == 255 || i == 256) begin
        checks++;
        if (illegal_count !== 8'd255) begin
          errors++; $display("FAIL illegal_sat[%0d]: got %0d want 255", i, illegal_count);
        end
      end
    end
    checks++;
    if (instr_count !== 16'd256) begin
      errors++; $display("FAIL illegal_instr_count: got %0d want 256", instr_count);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset_in_ext();
    cycle(1'b1, 16'hF900, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || instr_count !== 16'd0 || dut_b !== '0) begin
      errors++; $display("FAIL async_reset: v=%b count=%0d bundle=%h want 0", out_valid, instr_count, dut_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 16'h0123, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'h0 || use_imm !== 1'b0 || imm !== 16'h0
        || rd !== 4'd1 || rs !== 4'd2 || rt !== 4'd3 || reg_write !== 1'b1) begin
      errors++; $display("FAIL reset_in_ext: bundle=%h want add rd=1 rs=2 rt=3 no imm", dut_b);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_random();
    logic v, ordy;
    logic [15:0] w;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      w = 16'($urandom);
      if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
      cycle(v, w, ordy);
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, m_valid);
      end
      checks++;
      if (dut_b !== m_b) begin
        errors++; $display("FAIL rand_bundle[%0d]: got %h want %h", n, dut_b, m_b);
      end
      checks++;
      if (instr_count !== 16'(m_cnt) || illegal_count !== 8'(m_ill)) begin
        errors++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", n, instr_count, illegal_count, m_cnt, m_ill);
      end
      checks++;
      if (in_ready !== (!m_valid || ordy)) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, !m_valid || ordy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_imm();
    test_ldi();
    test_back_to_back();
    test_illegal_sat();
    test_reset_in_ext();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, instruction word on instr valid.
REQ-004 SHALL have port in_ready, output, 1, stage accepts instr this cycle.
REQ-005 SHALL have port instr, input, 16, instruction or extension word.
REQ-006 SHALL have port out_valid, output, 1, decoded bundle valid.
REQ-007 SHALL have port out_ready, input, 1, downstream ALU stage accepts bundle.
REQ-008 SHALL have port alu_control, output, 4, ALU op code (0000 add ... 1001 invert).
REQ-009 SHALL have ports rd, rs, rt, output, 4 each, register indices.
REQ-010 SHALL have port imm, output, 16, immediate operand.
REQ-011 SHALL have port use_imm, output, 1, B operand = imm instead of reg[rt].
REQ-012 SHALL have port reg_write, output, 1, result written to rd.
REQ-013 SHALL have port illegal, output, 1, undefined opcode flag.
REQ-014 SHALL have port instr_count, output, 16, decoded-bundle counter, wraps.
REQ-015 SHALL have port illegal_count, output, 8, illegal counter, saturates at 255.

Function
REQ-016 SHALL decode format: instr[15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-017 SHALL map opcodes 0000-1001 to alu_control equal to opcode, use_imm=0, reg_write=1, imm=0.
REQ-018 SHALL decode 1010 (ADDI): alu_control=0000, use_imm=1, imm=sign-extended imm4, rt=0.
REQ-019 SHALL decode 1011 (SLLI): alu_control=0011, use_imm=1, imm=zero-extended imm4, rt=0.
REQ-020 SHALL decode 1111 (LDI, two-word): first word captures rd/rs; next accepted word is imm[15:0]; alu_control=0110 (or), use_imm=1, reg_write=1.
REQ-021 SHALL treat 1100-1110 as illegal: illegal=1, alu_control=0000, reg_write=0, use_imm=0, imm=0, fields still passed.
REQ-022 SHALL implement FSM states IDLE (expect opcode word) and EXT (expect LDI extension word); IDLE->EXT on accepted 1111 word; EXT->IDLE on accepted extension word; no other transitions.
REQ-023 SHALL produce no bundle for an LDI first word; bundle emitted only on extension acceptance.
REQ-024 SHALL hold a single output register; in_ready = !out_valid || out_ready, in both states.
REQ-025 SHALL load the output register one cycle after an accepted word completing an instruction (latency 1); out_valid set then.
REQ-026 SHALL clear out_valid when out_ready=1 and no new bundle completes in the same cycle; simultaneous drain and load keeps out_valid=1 with new bundle.
REQ-027 SHALL keep all bundle outputs stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment instr_count once per bundle loaded (illegal included), wrapping 0xFFFF->0x0000.
REQ-029 SHALL increment illegal_count per illegal bundle loaded, holding at 255.
REQ-030 SHALL ignore instr when in_valid=0; in EXT state any word is taken as data, regardless of its top bits.

Reset
REQ-031 SHALL on rst_n=0, immediately and asynchronously, set FSM=IDLE, out_valid=0, all bundle outputs 0, instr_count=0, illegal_count=0; in_ready=1 after reset.
REQ-032 SHALL discard a pending LDI first word if reset asserts in EXT.

Verification
REQ-033 SHALL cover: instr=0x1234 valid, out_ready=1 -> next cycle out_valid=1, alu_control=0001, rd=2, rs=3, rt=4, reg_write=1, instr_count=1.
REQ-034 SHALL cover: 0xA21F (ADDI) -> alu_control=0000, use_imm=1, imm=0xFFFF, rd=2, rs=1.
REQ-035 SHALL cover: 0xF500 then 0xBEEF -> one bundle, rd=5, imm=0xBEEF, alu_control=0110, use_imm=1; no bundle after first word.
REQ-036 SHALL cover: out_ready=0 with out_valid=1 -> in_ready=0, outputs frozen; out_ready=1 with new word same cycle -> back-to-back bundles, no loss.
REQ-037 SHALL cover: 256 words 0xC000 -> illegal=1 each, illegal_count stops at 255, instr_count=256.
REQ-038 SHALL cover: rst_n low while in EXT -> FSM IDLE; next 0x0123 decodes as add, not immediate.
